vend_ctrl_param: RTL and testbench
==================================

Name: vend_ctrl_param

Overview:
Parametrised vending controller; next generation of the fixed 4-product, 35-cent controller.
- Product count, per-product prices, credit ceiling and vend pulse length are parameters.
- Coin inputs are edge-detected; over-limit coins are rejected.
- Change is paid out as a timed sequence of dime/nickel pulses.
- Sits between debounced front-panel switches/buttons and the seven-segment/LED driver; displays are 2-digit BCD.

Parameters:
- N_PROD, 4, number of products; one select switch and one vend LED each.
- CREDIT_W, 5, width of credit/price registers, in 5-cent units.
- MAX_CREDIT, 7, credit ceiling in units (7 = 35c). Must satisfy MAX_CREDIT*5 <= 95 and MAX_CREDIT < 2**CREDIT_W.
- PRICES, {5'd6,5'd5,5'd4,5'd3}, packed N_PROD*CREDIT_W; product i price in units at slice i (default 15/20/25/30c). Each price must be 1..MAX_CREDIT.
- VEND_CYCLES, 4, cycles vend_led is held (>=1).

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- coin  in  3  level coin sensors: [0] nickel (1 unit), [1] dime (2 units), [2] quarter (5 units)
- sel  in  N_PROD  product select switches, level, valid only when one-hot
- disp_credit  out  8  BCD cents of current credit (or remaining change while paying out)
- disp_price  out  8  BCD cents of selected product price; 8'h00 if sel not one-hot
- vend_led  out  N_PROD  one-hot dispensed product, held for VEND_CYCLES
- chg_dime  out  1  one-cycle pulse per dime returned
- chg_nickel  out  1  one-cycle pulse per nickel returned
- coin_rej  out  1  one-cycle pulse when an inserted coin is refused
- busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset: state ACCUM, credit=0, coin_q=0, all outputs 0 except the display decode of credit 0 (8'h00).
- Coin edges: coin_q registers coin every cycle; edge[k] = coin[k] & ~coin_q[k]. Credit updates on the same clk edge that sees the edge, so it is visible one cycle after the input rises.
- States: ACCUM, VEND, CHANGE.
- ACCUM, priority order:
  1. More than one edge in a cycle: all refused, coin_rej=1, credit unchanged.
  2. One edge, credit+weight <= MAX_CREDIT: credit += weight.
  3. One edge, credit+weight > MAX_CREDIT: coin_rej=1, credit unchanged (no saturation).
  4. No edge, sel one-hot, credit >= PRICES[i]: latch rem = credit - price and i; load vend counter with VEND_CYCLES-1; go to VEND.
  5. No edge, sel not one-hot or credit short: hold.
  A coin edge always has priority over selection in the same cycle.
- VEND: vend_led = one-hot(i) for exactly VEND_CYCLES cycles; counter decrements. At 0, go to CHANGE if rem > 0, else to ACCUM with credit=0.
- CHANGE: each cycle one coin out, largest first.
  - rem >= 2: chg_dime=1, rem -= 2.
  - rem == 1: chg_nickel=1, rem -= 1.
  - The cycle rem reaches 0: go to ACCUM with credit=0.
  - Total CHANGE cycles = floor(rem/2) + (rem mod 2).
- Any coin edge during VEND/CHANGE: coin_rej=1, no credit.
- sel changes after entering VEND are ignored.
- disp_credit shows credit in ACCUM and rem in VEND/CHANGE.
- clr mid-VEND/CHANGE aborts immediately: state ACCUM, rem and credit 0, pulses stop.
- Outputs are registered, except disp_price and disp_credit, which are decoded combinationally from registers/sel.

Optional Feature:
Macro VEND_CANCEL_EN.
- Defined: adds input `cancel` (1 bit, edge-detected like coins). In ACCUM with no coin edge and credit > 0, a cancel edge sets rem=credit and goes directly to CHANGE (refund, no vend). Cancel has priority over selection. Cancel is ignored in VEND/CHANGE and when credit == 0.
- Undefined: port absent; credit leaves only through a purchase.

Decomposition:
- Package vend_pkg:
  - state enum {ACCUM, VEND, CHANGE};
  - coin weight constants W_NICKEL=1, W_DIME=2, W_QUARTER=5;
  - function onehot_idx.
- Sub-module vend_units_to_bcd: combinational units -> 2-digit BCD cents (units*5). Instantiated twice, for credit/rem and price.

Test Plan:
- Defaults: nickel, dime, dime edges -> credit 5 units, disp_credit=8'h25, no coin_rej.
- Credit 6 units (30c), quarter edge -> coin_rej pulse, disp_credit stays 8'h30.
- Credit 7, sel=4'b0001 (price 3) -> vend_led=0001 for 4 cycles, then chg_dime, chg_dime (2 cycles), back to ACCUM with disp_credit=8'h00.
- Credit 4, sel=4'b0100 (price 5) -> no vend; sel=4'b0011 -> disp_price=8'h00, no vend.
- Nickel and dime rise in the same cycle -> coin_rej=1, credit unchanged. A coin edge during VEND -> coin_rej.
- clr asserted during the 2nd CHANGE cycle -> all outputs 0 asynchronously. With VEND_CANCEL_EN and credit 3, cancel -> chg_dime then chg_nickel, then credit 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller.
//   state_t     : controller states (ACCUM, VEND, CHANGE)
//   W_*         : coin weights in 5-cent units
//   onehot_idx  : index of the single set bit of a vector, -1 if not one-hot
package vend_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam int W_NICKEL  = 1;
   localparam int W_DIME    = 2;
   localparam int W_QUARTER = 5;

   // Returns the bit position when exactly one bit is set, otherwise -1.
   function automatic int onehot_idx(input logic [31:0] vec);
      int idx;
      int cnt;
      idx = 0;
      cnt = 0;
      for (int k = 0; k < 32; k++) begin
         if (vec[k]) begin
            idx = k;
            cnt = cnt + 1;
         end else begin
            idx = idx;
         end
      end
      if (cnt == 1) begin
         return idx;
      end else begin
         return -1;
      end
   endfunction

endpackage

// File: rtl/vend_units_to_bcd.sv
// Converts an amount in 5-cent units to two BCD digits of cents.
// Ports:
//   units_i : amount in units (units*5 must not exceed 95)
//   bcd_o   : {tens, ones} BCD cents
module vend_units_to_bcd #(
   parameter int W = 5
) (
   input  logic [W-1:0] units_i,
   output logic [7:0]   bcd_o
);

   logic [7:0] cents_s;
   logic [7:0] tens_s;
   logic [7:0] ones_s;

   // Scale to cents and split into decimal digits.
   always_comb begin
      cents_s = 8'(units_i) * 8'd5;
      tens_s  = cents_s / 8'd10;
      ones_s  = cents_s - (tens_s * 8'd10);
      bcd_o   = (tens_s << 3'd4) | ones_s;
   end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: accumulates edge-detected coins up to a
// credit ceiling, vends the one-hot selected product when credit covers its
// price, then pays change back as dime/nickel pulses.
// Optional macro VEND_CANCEL_EN adds a 'cancel' input that refunds the whole
// credit as change without vending.
// Ports:
//   clk, clr     : clock, asynchronous active-high reset
//   coin[2:0]    : level sensors {quarter, dime, nickel}
//   sel          : product select switches (valid only when one-hot)
//   cancel       : refund request (only with VEND_CANCEL_EN)
//   disp_credit  : BCD cents of credit (ACCUM) or remaining change (VEND/CHANGE)
//   disp_price   : BCD cents of selected price, 8'h00 if sel not one-hot
//   vend_led     : one-hot dispensed product, held VEND_CYCLES cycles
//   chg_dime, chg_nickel, coin_rej : one-cycle pulses
//   busy         : high in VEND and CHANGE
module vend_ctrl_param
   import vend_pkg::*;
#(
   parameter int                         N_PROD      = 4,
   parameter int                         CREDIT_W    = 5,
   parameter int                         MAX_CREDIT  = 7,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {5'd6, 5'd5, 5'd4, 5'd3},
   parameter int                         VEND_CYCLES = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [2:0]        coin,
   input  logic [N_PROD-1:0] sel,
`ifdef VEND_CANCEL_EN
   input  logic              cancel,
`endif
   output logic [7:0]        disp_credit,
   output logic [7:0]        disp_price,
   output logic [N_PROD-1:0] vend_led,
   output logic              chg_dime,
   output logic              chg_nickel,
   output logic              coin_rej,
   output logic              busy
);

   localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
   localparam int VC_W  = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES + 1) : 1;
   localparam logic [VC_W-1:0]     VC_LOAD = VC_W'(VEND_CYCLES - 1);
   localparam logic [CREDIT_W:0]   MAX_U   = (CREDIT_W + 1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] U_ONE   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] U_TWO   = CREDIT_W'(2);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] rem_q, rem_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VC_W-1:0]     vcnt_q, vcnt_d;
   logic [2:0]          coin_q;
   logic [N_PROD-1:0]   vend_led_q, vend_led_d;
   logic                chg_dime_q, chg_dime_d;
   logic                chg_nickel_q, chg_nickel_d;
   logic                coin_rej_q, coin_rej_d;
   logic                busy_q, busy_d;

   logic [2:0]          edge_s;
   logic                any_edge_s;
   logic                multi_s;
   logic [2:0]          weight_s;
   logic [CREDIT_W:0]   sum_s;
   int                  sel_idx_s;
   logic                sel_ok_s;
   logic [CREDIT_W-1:0] price_sel_s;
   logic [CREDIT_W-1:0] disp_units_s;

`ifdef VEND_CANCEL_EN
   logic                cancel_q;
   logic                cancel_edge_s;
   assign cancel_edge_s = cancel & ~cancel_q;
`endif

   // Coin edge detection and weight of a single edge.
   always_comb begin
      edge_s     = coin & ~coin_q;
      any_edge_s = (edge_s != 3'd0);
      // More than one bit set: clearing the lowest set bit leaves something.
      multi_s    = ((edge_s & (edge_s - 3'd1)) != 3'd0);
      case (edge_s)
         3'b001:  weight_s = 3'(W_NICKEL);
         3'b010:  weight_s = 3'(W_DIME);
         3'b100:  weight_s = 3'(W_QUARTER);
         default: weight_s = 3'd0;
      endcase
      sum_s = {1'b0, credit_q} + (CREDIT_W + 1)'(weight_s);
   end

   // Selected product index and price lookup; price 0 when sel is not one-hot.
   always_comb begin
      sel_idx_s   = onehot_idx(32'(sel));
      sel_ok_s    = (sel_idx_s >= 0);
      price_sel_s = '0;
      for (int p = 0; p < N_PROD; p++) begin
         if (sel_idx_s == p) begin
            price_sel_s = PRICES[p*CREDIT_W +: CREDIT_W];
         end else begin
            price_sel_s = price_sel_s;
         end
      end
   end

   // Next-state, datapath and registered-output decisions.
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      rem_d      = rem_q;
      idx_d      = idx_q;
      vcnt_d     = vcnt_q;
      coin_rej_d = 1'b0;
      case (state_q)
         ACCUM: begin
            if (multi_s) begin
               coin_rej_d = 1'b1;
            end else if (any_edge_s) begin
               // No saturation: an over-limit coin is refused whole.
               if (sum_s <= MAX_U) begin
                  credit_d = sum_s[CREDIT_W-1:0];
               end else begin
                  coin_rej_d = 1'b1;
               end
            end
`ifdef VEND_CANCEL_EN
            else if (cancel_edge_s && (credit_q != '0)) begin
               rem_d    = credit_q;
               credit_d = '0;
               state_d  = CHANGE;
            end
`endif
            else if (sel_ok_s && (credit_q >= price_sel_s)) begin
               rem_d    = credit_q - price_sel_s;
               idx_d    = IDX_W'(sel_idx_s);
               vcnt_d   = VC_LOAD;
               credit_d = '0;
               state_d  = VEND;
            end else begin
               state_d = ACCUM;
            end
         end
         VEND: begin
            coin_rej_d = any_edge_s;
            if (vcnt_q == '0) begin
               credit_d = '0;
               if (rem_q != '0) begin
                  state_d = CHANGE;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               vcnt_d = vcnt_q - VC_W'(1);
            end
         end
         CHANGE: begin
            coin_rej_d = any_edge_s;
            if (rem_q >= U_TWO) begin
               rem_d = rem_q - U_TWO;
            end else if (rem_q == U_ONE) begin
               rem_d = '0;
            end else begin
               rem_d = '0;
            end
            if (rem_d == '0) begin
               credit_d = '0;
               state_d  = ACCUM;
            end else begin
               state_d = CHANGE;
            end
         end
         default: begin
            state_d  = ACCUM;
            credit_d = '0;
            rem_d    = '0;
         end
      endcase

      // Outputs describe the cycle being entered, so they line up with state_q.
      busy_d       = (state_d != ACCUM);
      chg_dime_d   = (state_d == CHANGE) && (rem_d >= U_TWO);
      chg_nickel_d = (state_d == CHANGE) && (rem_d == U_ONE);
      if (state_d == VEND) begin
         vend_led_d = N_PROD'(1) << idx_d;
      end else begin
         vend_led_d = '0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ACCUM;
         credit_q     <= '0;
         rem_q        <= '0;
         idx_q        <= '0;
         vcnt_q       <= '0;
         coin_q       <= 3'd0;
         vend_led_q   <= '0;
         chg_dime_q   <= 1'b0;
         chg_nickel_q <= 1'b0;
         coin_rej_q   <= 1'b0;
         busy_q       <= 1'b0;
`ifdef VEND_CANCEL_EN
         cancel_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         rem_q        <= rem_d;
         idx_q        <= idx_d;
         vcnt_q       <= vcnt_d;
         coin_q       <= coin;
         vend_led_q   <= vend_led_d;
         chg_dime_q   <= chg_dime_d;
         chg_nickel_q <= chg_nickel_d;
         coin_rej_q   <= coin_rej_d;
         busy_q       <= busy_d;
`ifdef VEND_CANCEL_EN
         cancel_q     <= cancel;
`endif
      end
   end

   // Credit display source: remaining change once a transaction is running.
   always_comb begin
      if (state_q == ACCUM) begin
         disp_units_s = credit_q;
      end else begin
         disp_units_s = rem_q;
      end
   end

   vend_units_to_bcd #(.W(CREDIT_W)) u_bcd_credit (
      .units_i (disp_units_s),
      .bcd_o   (disp_credit)
   );

   vend_units_to_bcd #(.W(CREDIT_W)) u_bcd_price (
      .units_i (price_sel_s),
      .bcd_o   (disp_price)
   );

   assign vend_led   = vend_led_q;
   assign chg_dime   = chg_dime_q;
   assign chg_nickel = chg_nickel_q;
   assign coin_rej   = coin_rej_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed scenarios plus random
// stimulus, all compared with a transaction-level reference model that
// plans each purchase as a queue of per-cycle output slots.
module tb_vend_ctrl_param;

   localparam int N_PROD = 4;
   localparam int CREDIT_W = 5;
   localparam int MAX_CREDIT = 7;
   localparam int VEND_CYCLES = 4;
   localparam logic [19:0] PRICES = {5'd6, 5'd5, 5'd4, 5'd3};

   logic       clk;
   logic       clr;
   logic [2:0] coin;
   logic [3:0] sel;
`ifdef VEND_CANCEL_EN
   logic       cancel;
`endif
   logic [7:0] disp_credit;
   logic [7:0] disp_price;
   logic [3:0] vend_led;
   logic       chg_dime;
   logic       chg_nickel;
   logic       coin_rej;
   logic       busy;

   vend_ctrl_param #(
      .N_PROD(N_PROD), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT),
      .PRICES(PRICES), .VEND_CYCLES(VEND_CYCLES)
   ) dut (
      .clk(clk), .clr(clr), .coin(coin), .sel(sel),
`ifdef VEND_CANCEL_EN
      .cancel(cancel),
`endif
      .disp_credit(disp_credit), .disp_price(disp_price), .vend_led(vend_led),
      .chg_dime(chg_dime), .chg_nickel(chg_nickel), .coin_rej(coin_rej), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0] led;
      logic       dime;
      logic       nick;
      int         units;
   } slot_t;

   slot_t      sched[$];
   int         m_credit;
   logic [2:0] m_prev_coin;
   logic       m_prev_cancel;
   logic       m_rej;
   int         n_checks = 0;
   int         n_fail = 0;

   function automatic int price_of(int i);
      return int'(PRICES[i*5 +: 5]);
   endfunction

   function automatic logic [7:0] bcd(int u);
      int c;
      c = u * 5;
      return 8'((c / 10) * 16 + (c % 10));
   endfunction

   function automatic int oh(logic [3:0] s);
      if ($countones(s) != 1) return -1;
      for (int k = 0; k < 4; k++) if (s[k]) return k;
      return -1;
   endfunction

   task automatic plan_change(int r);
      slot_t s;
      while (r >= 2) begin
         s.led = 4'd0; s.dime = 1'b1; s.nick = 1'b0; s.units = r;
         sched.push_back(s);
         r = r - 2;
      end
      if (r == 1) begin
         s.led = 4'd0; s.dime = 1'b0; s.nick = 1'b1; s.units = 1;
         sched.push_back(s);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      m_credit = 0;
      m_prev_coin = 3'd0;
      m_prev_cancel = 1'b0;
      m_rej = 1'b0;
   endtask

   // Applies the rules to the inputs present at a rising clock edge.
   task automatic model_edge();
      logic [2:0] e;
      logic       ce;
      int         w, i, rem;
      slot_t      s;
      e = coin & ~m_prev_coin;
      m_prev_coin = coin;
      ce = 1'b0;
`ifdef VEND_CANCEL_EN
      ce = cancel & ~m_prev_cancel;
      m_prev_cancel = cancel;
`endif
      m_rej = 1'b0;
      i = oh(sel);
      if (sched.size() > 0) begin
         m_rej = (e != 3'd0);
         sched.delete(0);
      end else if ($countones(e) > 1) begin
         m_rej = 1'b1;
      end else if (e != 3'd0) begin
         w = e[0] ? 1 : (e[1] ? 2 : 5);
         if (m_credit + w <= MAX_CREDIT) m_credit = m_credit + w;
         else m_rej = 1'b1;
      end else if (ce && m_credit > 0) begin
         plan_change(m_credit);
         m_credit = 0;
      end else if (i >= 0 && m_credit >= price_of(i)) begin
         rem = m_credit - price_of(i);
         for (int k = 0; k < VEND_CYCLES; k++) begin
            s.led = 4'(1 << i); s.dime = 1'b0; s.nick = 1'b0; s.units = rem;
            sched.push_back(s);
         end
         plan_change(rem);
         m_credit = 0;
      end
   endtask

   function automatic logic [23:0] exp_vec();
      logic [7:0] pd;
      pd = (oh(sel) >= 0) ? bcd(price_of(oh(sel))) : 8'h00;
      if (sched.size() > 0)
         return {bcd(sched[0].units), pd, sched[0].led, sched[0].dime, sched[0].nick, m_rej, 1'b1};
      else
         return {bcd(m_credit), pd, 4'd0, 1'b0, 1'b0, m_rej, 1'b0};
   endfunction

   function automatic logic [23:0] obs();
      return {disp_credit, disp_price, vend_led, chg_dime, chg_nickel, coin_rej, busy};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clr = 1'b1; coin = 3'd0; sel = 4'd0;
`ifdef VEND_CANCEL_EN
      cancel = 1'b0;
`endif
      #12;
      n_checks++;
      if (obs() !== 24'h0) begin
         n_fail++; $display("FAIL reset_outputs got %h want %h", obs(), 24'h0);
      end
      @(negedge clk); clr = 1'b0; model_reset();
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_idle got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_coins();
      logic [2:0] seq [6];
      seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
      for (int k = 0; k < 6; k++) begin
         coin = seq[k];
         step();
         n_checks++;
         if (obs() !== exp_vec() || coin_rej !== 1'b0) begin
            n_fail++; $display("FAIL coins_step%0d got %h want %h", k, obs(), exp_vec());
         end
      end
      n_checks++;
      if (disp_credit !== 8'h25) begin
         n_fail++; $display("FAIL coins_credit got %h want %h", disp_credit, 8'h25);
      end
   endtask

   task automatic test_reject_over();
      coin = 3'b001; step(); coin = 3'b000; step();
      n_checks++;
      if (disp_credit !== 8'h30) begin
         n_fail++; $display("FAIL over_pre got %h want %h", disp_credit, 8'h30);
      end
      coin = 3'b100; step();
      n_checks++;
      if (coin_rej !== 1'b1 || disp_credit !== 8'h30 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL over_quarter got %h want %h", obs(), exp_vec());
      end
      coin = 3'b000; step();
      n_checks++;
      if (coin_rej !== 1'b0 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL over_after got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_vend_change();
      coin = 3'b001; step(); coin = 3'b000; step();
      sel = 4'b0001; step();
      for (int k = 0; k < VEND_CYCLES; k++) begin
         n_checks++;
         if (vend_led !== 4'b0001 || busy !== 1'b1 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL vend_cycle%0d got %h want %h", k, obs(), exp_vec());
         end
         sel = 4'b0010;
         step();
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (chg_dime !== 1'b1 || chg_nickel !== 1'b0 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL change_dime%0d got %h want %h", k, obs(), exp_vec());
         end
         step();
      end
      n_checks++;
      if (busy !== 1'b0 || disp_credit !== 8'h00 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL vend_done got %h want %h", obs(), exp_vec());
      end
      sel = 4'b0000; step();
   endtask

   task automatic test_short();
      coin = 3'b010; step(); coin = 3'b000; step();
      coin = 3'b010; step(); coin = 3'b000; step();
      sel = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (busy !== 1'b0 || disp_price !== 8'h25 || disp_credit !== 8'h20 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL short_price got %h want %h", obs(), exp_vec());
         end
      end
      sel = 4'b0011; step();
      n_checks++;
      if (disp_price !== 8'h00 || busy !== 1'b0 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL short_multisel got %h want %h", obs(), exp_vec());
      end
      sel = 4'b0000; step();
   endtask

   task automatic test_multi_edge();
      coin = 3'b011; step();
      n_checks++;
      if (coin_rej !== 1'b1 || disp_credit !== 8'h20 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL multi_edge got %h want %h", obs(), exp_vec());
      end
      coin = 3'b000; step();
      sel = 4'b0001; step();
      sel = 4'b0000; coin = 3'b100; step();
      n_checks++;
      if (coin_rej !== 1'b1 || busy !== 1'b1 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL coin_in_vend got %h want %h", obs(), exp_vec());
      end
      coin = 3'b000;
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_fail++; $display("FAIL multi_drain%0d got %h want %h", k, obs(), exp_vec());
         end
      end
      n_checks++;
      if (busy !== 1'b0 || disp_credit !== 8'h00) begin
         n_fail++; $display("FAIL multi_idle got %h want %h", {busy, disp_credit}, 9'h000);
      end
   endtask

   task automatic test_clr_mid_change();
      coin = 3'b100; step(); coin = 3'b000; step();
      coin = 3'b010; step(); coin = 3'b000; step();
      sel = 4'b0001; step();
      sel = 4'b0000;
      for (int k = 0; k < VEND_CYCLES + 1; k++) step();
      n_checks++;
      if (chg_dime !== 1'b1 || disp_credit !== 8'h10 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL clr_pre got %h want %h", obs(), exp_vec());
      end
      #2 clr = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 24'h0) begin
         n_fail++; $display("FAIL clr_async got %h want %h", obs(), 24'h0);
      end
      model_reset();
      @(negedge clk); clr = 1'b0;
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL clr_after got %h want %h", obs(), exp_vec());
      end
   endtask

`ifdef VEND_CANCEL_EN
   task automatic test_cancel();
      coin = 3'b001; step(); coin = 3'b000; step();
      coin = 3'b010; step(); coin = 3'b000; step();
      cancel = 1'b1; step();
      n_checks++;
      if (chg_dime !== 1'b1 || busy !== 1'b1 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL cancel_dime got %h want %h", obs(), exp_vec());
      end
      cancel = 1'b0; step();
      n_checks++;
      if (chg_nickel !== 1'b1 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL cancel_nickel got %h want %h", obs(), exp_vec());
      end
      step();
      n_checks++;
      if (disp_credit !== 8'h00 || busy !== 1'b0 || obs() !== exp_vec()) begin
         n_fail++; $display("FAIL cancel_done got %h want %h", obs(), exp_vec());
      end
   endtask
`endif

   task automatic test_random();
      logic [3:0] sel_tab [7];
      int errs;
      sel_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000};
      errs = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0) coin = 3'($urandom_range(0, 7));
         else coin = 3'd0;
         if ($urandom_range(0, 7) == 0) sel = sel_tab[$urandom_range(0, 6)];
         else sel = sel;
`ifdef VEND_CANCEL_EN
         cancel = ($urandom_range(0, 15) == 0);
`endif
         step();
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_fail++;
            if (errs < 10) $display("FAIL random_cycle%0d got %h want %h", k, obs(), exp_vec());
            errs++;
         end
      end
      coin = 3'd0; sel = 4'd0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_coins();
      test_reject_over();
      test_vend_change();
      test_short();
      test_multi_edge();
      test_clr_mid_change();
`ifdef VEND_CANCEL_EN
      test_cancel();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
